// File: rtl/pipelined_controller.sv
// pipelined_controller -- decode-stage control unit for the 5-stage MIPS pipeline.
// Decodes opcode/funct/rt into a control word, registers it into the ID/EX
// control fields, inserts STALL_CYCLES bubbles on a load-use hazard and
// flushes on a taken branch/jump resolved in EX.
// Optional build macro: HAZARD_STATS_EN enables the 16-bit saturating
// StallCount/FlushCount statistics; without it both ports are tied to 0.
module pipelined_controller #(
  parameter int OPCODE_W     = 6,
  parameter int REG_ADDR_W   = 5,
  parameter int INSTR_SEL_W  = 4,
  parameter int STALL_CYCLES = 1
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [OPCODE_W-1:0]    Instruction,
  input  logic [OPCODE_W-1:0]    Funct,
  input  logic [REG_ADDR_W-1:0]  BranchSignal,
  input  logic [REG_ADDR_W-1:0]  Rs_ID,
  input  logic [REG_ADDR_W-1:0]  Rt_ID,
  input  logic                   ID_Valid,
  input  logic                   EX_MemRead,
  input  logic [REG_ADDR_W-1:0]  EX_Rd,
  input  logic                   BranchTaken,
  output logic                   PCWrite,
  output logic                   IFID_Write,
  output logic                   IFID_Flush,
  output logic                   PCSrc,
  output logic                   RegSrc0,
  output logic                   RegSrc1,
  output logic                   ExtendSel,
  output logic                   RegDst,
  output logic                   ALUSrc0,
  output logic                   R_Enable,
  output logic                   W_Enable,
  output logic                   MemToReg,
  output logic                   RegWrite,
  output logic [1:0]             ALUSrc1,
  output logic [1:0]             R_Width,
  output logic [1:0]             W_Width,
  output logic [INSTR_SEL_W-1:0] InstrSel,
  output logic                   Ctrl_Valid,
  output logic                   Illegal,
  output logic [15:0]            StallCount,
  output logic [15:0]            FlushCount
);

  localparam int CNT_W = (STALL_CYCLES < 2) ? 1 : $clog2(STALL_CYCLES + 1);

  typedef enum logic [0:0] {RUN, STALL} state_t;

  typedef struct packed {
    logic                   pc_src;
    logic                   reg_src0;
    logic                   reg_src1;
    logic                   extend_sel;
    logic                   reg_dst;
    logic                   alu_src0;
    logic                   r_enable;
    logic                   w_enable;
    logic                   mem_to_reg;
    logic                   reg_write;
    logic [1:0]             alu_src1;
    logic [1:0]             r_width;
    logic [1:0]             w_width;
    logic [INSTR_SEL_W-1:0] instr_sel;
    logic                   valid;
    logic                   illegal;
  } ctrl_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            dec, ctrl_d, ctrl_q;
  logic             reads_rt;
  logic             hazard;

  // Instruction decode: opcode/funct/rt to control word, plus whether rt is a source.
  always_comb begin
    // NOTE: every field gets a default before the case so no path infers a latch
    // and unused widths decode to 0 rather than X.
    dec       = '0;
    dec.valid = 1'b1;
    reads_rt  = 1'b0;
    case (Instruction)
      6'b000000: begin
        reads_rt      = 1'b1;
        dec.reg_dst   = 1'b1;
        dec.reg_write = 1'b1;
        if (Funct == 6'b000000 || Funct == 6'b000010) dec.alu_src0 = 1'b1;
        if (Funct == 6'b001000) begin
          dec.reg_write = 1'b0;
          dec.pc_src    = 1'b1;
          dec.instr_sel = INSTR_SEL_W'(7);
        end
      end
      6'b011100: begin
        reads_rt      = 1'b1;
        dec.reg_write = 1'b1;
      end
      6'b100011, 6'b100001, 6'b100000: begin
        dec.r_enable   = 1'b1;
        dec.reg_write  = 1'b1;
        dec.alu_src1   = 2'd1;
        dec.extend_sel = 1'b1;
        dec.r_width    = (Instruction == 6'b100011) ? 2'd0 :
                         (Instruction == 6'b100001) ? 2'd1 : 2'd2;
      end
      6'b101011, 6'b101001, 6'b101000: begin
        reads_rt     = 1'b1;
        dec.w_enable = 1'b1;
        dec.w_width  = (Instruction == 6'b101011) ? 2'd0 :
                       (Instruction == 6'b101001) ? 2'd1 : 2'd2;
      end
      6'b000001: begin
        if (BranchSignal == '0) begin
          dec.pc_src     = 1'b1;
          dec.extend_sel = 1'b1;
          dec.instr_sel  = INSTR_SEL_W'(5);
        end else if (BranchSignal == REG_ADDR_W'(1)) begin
          dec.pc_src     = 1'b1;
          dec.extend_sel = 1'b1;
          dec.instr_sel  = INSTR_SEL_W'(0);
        end else begin
          dec         = '0;
          dec.valid   = 1'b1;
          dec.illegal = 1'b1;
        end
      end
      6'b000100, 6'b000101, 6'b000111, 6'b000110: begin
        reads_rt       = (Instruction == 6'b000100) || (Instruction == 6'b000101);
        dec.pc_src     = 1'b1;
        dec.extend_sel = 1'b1;
        case (Instruction)
          6'b000100: dec.instr_sel = INSTR_SEL_W'(1);
          6'b000101: dec.instr_sel = INSTR_SEL_W'(2);
          6'b000111: dec.instr_sel = INSTR_SEL_W'(3);
          default:   dec.instr_sel = INSTR_SEL_W'(4);
        endcase
      end
      6'b000010: dec.instr_sel = INSTR_SEL_W'(6);
      6'b000011: begin
        dec.instr_sel = INSTR_SEL_W'(8);
        dec.reg_write = 1'b1;
        dec.alu_src1  = 2'd2;
      end
      6'b001000, 6'b001101, 6'b001110, 6'b001010: begin
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
        dec.alu_src1   = 2'd1;
        dec.extend_sel = (Instruction == 6'b001000) || (Instruction == 6'b001010);
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // Load-use hazard against the load currently in EX.
  assign hazard = EX_MemRead && (EX_Rd != '0) && ID_Valid &&
                  ((EX_Rd == Rs_ID) || (reads_rt && (EX_Rd == Rt_ID)));

  // Stall/flush FSM: next state, bubble counter, fetch controls and next ID/EX word.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    PCWrite    = 1'b1;
    IFID_Write = 1'b1;
    IFID_Flush = 1'b0;
    ctrl_d     = '0;
    if (Reset) begin
      PCWrite    = 1'b0;
      IFID_Write = 1'b0;
      state_d    = RUN;
      cnt_d      = '0;
    end else if (BranchTaken) begin
      IFID_Flush = 1'b1;
      state_d    = RUN;
      cnt_d      = '0;
    end else begin
      case (state_q)
        STALL: begin
          PCWrite    = 1'b0;
          IFID_Write = 1'b0;
          cnt_d      = cnt_q - 1'b1;
          if (cnt_q <= CNT_W'(1)) state_d = RUN;
        end
        default: begin
          if (hazard) begin
            PCWrite    = 1'b0;
            IFID_Write = 1'b0;
            cnt_d      = CNT_W'(STALL_CYCLES - 1);
            state_d    = (STALL_CYCLES > 1) ? STALL : RUN;
          end else if (ID_Valid) begin
            ctrl_d = dec;
          end
        end
      endcase
    end
  end

  // State, counter and ID/EX control register with synchronous reset.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (Reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign PCSrc      = ctrl_q.pc_src;
  assign RegSrc0    = ctrl_q.reg_src0;
  assign RegSrc1    = ctrl_q.reg_src1;
  assign ExtendSel  = ctrl_q.extend_sel;
  assign RegDst     = ctrl_q.reg_dst;
  assign ALUSrc0    = ctrl_q.alu_src0;
  assign R_Enable   = ctrl_q.r_enable;
  assign W_Enable   = ctrl_q.w_enable;
  assign MemToReg   = ctrl_q.mem_to_reg;
  assign RegWrite   = ctrl_q.reg_write;
  assign ALUSrc1    = ctrl_q.alu_src1;
  assign R_Width    = ctrl_q.r_width;
  assign W_Width    = ctrl_q.w_width;
  assign InstrSel   = ctrl_q.instr_sel;
  assign Ctrl_Valid = ctrl_q.valid;
  assign Illegal    = ctrl_q.illegal;

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;
  logic        hazard_bubble;

  assign hazard_bubble = !BranchTaken && ((state_q == STALL) || hazard);

  // Saturating statistics counters for hazard bubbles and flushes.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (hazard_bubble && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (BranchTaken && flush_cnt_q != 16'hFFFF)   flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;
`else
  assign StallCount = 16'd0;
  assign FlushCount = 16'd0;
`endif

endmodule

// File: tb/tb_pipelined_controller.sv
// tb_pipelined_controller -- directed and randomized bench for pipelined_controller,
// compared against a behavioural model of decode, bubbles and statistics.
module tb_pipelined_controller;

  localparam int STALL = 2;

  logic        Clk;
  logic        Reset;
  logic [5:0]  Instruction, Funct;
  logic [4:0]  BranchSignal, Rs_ID, Rt_ID, EX_Rd;
  logic        ID_Valid, EX_MemRead, BranchTaken;
  logic        PCWrite, IFID_Write, IFID_Flush;
  logic        PCSrc, RegSrc0, RegSrc1, ExtendSel, RegDst, ALUSrc0;
  logic        R_Enable, W_Enable, MemToReg, RegWrite;
  logic [1:0]  ALUSrc1, R_Width, W_Width;
  logic [3:0]  InstrSel;
  logic        Ctrl_Valid, Illegal;
  logic [15:0] StallCount, FlushCount;

  int checks = 0;
  int errors = 0;

  // Model state: expected registered word, bubbles still owed, statistics.
  logic [21:0] m_word;
  int          m_left;
  int          m_stall;
  int          m_flush;

  pipelined_controller #(.STALL_CYCLES(STALL)) dut (
    .Clk(Clk), .Reset(Reset), .Instruction(Instruction), .Funct(Funct),
    .BranchSignal(BranchSignal), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .ID_Valid(ID_Valid),
    .EX_MemRead(EX_MemRead), .EX_Rd(EX_Rd), .BranchTaken(BranchTaken),
    .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
    .PCSrc(PCSrc), .RegSrc0(RegSrc0), .RegSrc1(RegSrc1), .ExtendSel(ExtendSel),
    .RegDst(RegDst), .ALUSrc0(ALUSrc0), .R_Enable(R_Enable), .W_Enable(W_Enable),
    .MemToReg(MemToReg), .RegWrite(RegWrite), .ALUSrc1(ALUSrc1), .R_Width(R_Width),
    .W_Width(W_Width), .InstrSel(InstrSel), .Ctrl_Valid(Ctrl_Valid), .Illegal(Illegal),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  wire [21:0] act_word = {PCSrc, RegSrc0, RegSrc1, ExtendSel, RegDst, ALUSrc0, R_Enable,
                          W_Enable, MemToReg, RegWrite, ALUSrc1, R_Width, W_Width,
                          InstrSel, Ctrl_Valid, Illegal};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected control word for an issued instruction, from the opcode table.
  function automatic logic [21:0] ref_word(input logic [5:0] op, input logic [5:0] fn,
                                           input logic [4:0] rt);
    bit pcsrc = 0, ext = 0, rdst = 0, a0 = 0, ren = 0, wen = 0, m2r = 0, rw = 0, ill = 0;
    bit [1:0] a1 = 0, rwid = 0, wwid = 0;
    bit [3:0] isel = 0;
    case (op)
      6'd0: begin
        rdst = 1; rw = 1;
        if (fn == 6'd0 || fn == 6'd2) a0 = 1;
        if (fn == 6'd8) begin rw = 0; pcsrc = 1; isel = 7; end
      end
      6'h1c: rw = 1;
      6'd35: begin ren = 1; rw = 1; a1 = 1; ext = 1; rwid = 0; end
      6'd33: begin ren = 1; rw = 1; a1 = 1; ext = 1; rwid = 1; end
      6'd32: begin ren = 1; rw = 1; a1 = 1; ext = 1; rwid = 2; end
      6'd43: begin wen = 1; wwid = 0; end
      6'd41: begin wen = 1; wwid = 1; end
      6'd40: begin wen = 1; wwid = 2; end
      6'd1: begin
        if (rt == 5'd0)      begin pcsrc = 1; ext = 1; isel = 5; end
        else if (rt == 5'd1) begin pcsrc = 1; ext = 1; isel = 0; end
        else ill = 1;
      end
      6'd4: begin pcsrc = 1; ext = 1; isel = 1; end
      6'd5: begin pcsrc = 1; ext = 1; isel = 2; end
      6'd7: begin pcsrc = 1; ext = 1; isel = 3; end
      6'd6: begin pcsrc = 1; ext = 1; isel = 4; end
      6'd2: isel = 6;
      6'd3: begin isel = 8; rw = 1; a1 = 2; end
      6'd8, 6'd10: begin m2r = 1; rw = 1; a1 = 1; ext = 1; end
      6'd13, 6'd14: begin m2r = 1; rw = 1; a1 = 1; end
      default: ill = 1;
    endcase
    return {pcsrc, 1'b0, 1'b0, ext, rdst, a0, ren, wen, m2r, rw, a1, rwid, wwid, isel, 1'b1, ill};
  endfunction

  function automatic bit reads_rt(input logic [5:0] op);
    return op == 6'd0 || op == 6'h1c || op == 6'd43 || op == 6'd41 || op == 6'd40 ||
           op == 6'd4 || op == 6'd5;
  endfunction

  // One clock: check fetch controls before the edge, advance the model, check
  // registered controls and statistics after the edge.
  task automatic cycle(input string tag);
    logic [2:0] exp_fetch;
    bit hz;
    #1;
    hz = EX_MemRead && EX_Rd != 5'd0 && ID_Valid &&
         (EX_Rd == Rs_ID || (reads_rt(Instruction) && EX_Rd == Rt_ID));
    if (Reset)                  exp_fetch = 3'b000;
    else if (BranchTaken)       exp_fetch = 3'b111;
    else if (m_left > 0 || hz)  exp_fetch = 3'b000;
    else                        exp_fetch = 3'b110;
    check({tag, "/fetch"}, 32'({PCWrite, IFID_Write, IFID_Flush}), 32'(exp_fetch));
    if (Reset) begin
      m_word = '0; m_left = 0; m_stall = 0; m_flush = 0;
    end else if (BranchTaken) begin
      m_word = '0; m_left = 0;
      if (m_flush < 65535) m_flush++;
    end else if (m_left > 0) begin
      m_word = '0; m_left--;
      if (m_stall < 65535) m_stall++;
    end else if (hz) begin
      m_word = '0; m_left = STALL - 1;
      if (m_stall < 65535) m_stall++;
    end else if (!ID_Valid) begin
      m_word = '0;
    end else begin
      m_word = ref_word(Instruction, Funct, BranchSignal);
    end
    @(posedge Clk);
    #1;
    check({tag, "/ctrl"}, 32'(act_word), 32'(m_word));
`ifdef HAZARD_STATS_EN
    check({tag, "/stats"}, {StallCount, FlushCount}, {16'(m_stall), 16'(m_flush)});
`else
    check({tag, "/stats"}, {StallCount, FlushCount}, 32'd0);
`endif
    @(negedge Clk);
  endtask

  task automatic set_id(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                        input logic [4:0] rt);
    Instruction = op; Funct = fn; Rs_ID = rs; Rt_ID = rt; BranchSignal = rt; ID_Valid = 1'b1;
  endtask

  task automatic set_ex(input logic mr, input logic [4:0] rd);
    EX_MemRead = mr; EX_Rd = rd;
  endtask

  logic [5:0] op_pool [22] = '{6'd0, 6'd0, 6'h1c, 6'd35, 6'd33, 6'd32, 6'd43, 6'd41, 6'd40,
                               6'd1, 6'd4, 6'd5, 6'd7, 6'd6, 6'd2, 6'd3, 6'd8, 6'd13,
                               6'd14, 6'd10, 6'd63, 6'h11};
  logic [5:0] fn_pool [6] = '{6'd0, 6'd2, 6'd8, 6'd32, 6'd34, 6'd42};

  initial begin
    m_word = '0; m_left = 0; m_stall = 0; m_flush = 0;
    Reset = 1'b1; ID_Valid = 1'b0; BranchTaken = 1'b0;
    set_id(6'd0, 6'd0, 5'd0, 5'd0); ID_Valid = 1'b0;
    set_ex(1'b0, 5'd0);
    @(negedge Clk);
    cycle("reset0");
    cycle("reset1");
    Reset = 1'b0;

    // lw issues one clock after ID.
    set_id(6'd35, 6'd0, 5'd1, 5'd2);
    cycle("lw");
    check("lw_ren", 32'(R_Enable), 32'd1);

    // Load-use on rs: two bubbles, then the add issues.
    set_ex(1'b1, 5'd8);
    set_id(6'd0, 6'd32, 5'd8, 5'd9);
    cycle("hz_rs0");
    cycle("hz_rs1");
    check("hz_bubble", 32'(Ctrl_Valid), 32'd0);
    set_ex(1'b0, 5'd0);
    cycle("hz_issue");

    // EX_Rd = 0 never stalls; addi does not read rt.
    set_ex(1'b1, 5'd0);
    set_id(6'd0, 6'd32, 5'd0, 5'd0);
    cycle("rd_zero");
    set_ex(1'b1, 5'd8);
    set_id(6'd8, 6'd0, 5'd3, 5'd8);
    cycle("addi_rt");
    set_id(6'd43, 6'd0, 5'd3, 5'd8);
    cycle("sw_rt_hz0");
    cycle("sw_rt_hz1");

    // Flush in the first stall cycle.
    set_id(6'd0, 6'd32, 5'd8, 5'd0);
    cycle("fl_hz");
    BranchTaken = 1'b1;
    cycle("fl_flush");
    BranchTaken = 1'b0;
    set_ex(1'b0, 5'd0);
    set_id(6'd4, 6'd0, 5'd1, 5'd2);
    cycle("fl_after");

    // Illegal opcodes.
    set_id(6'd63, 6'd0, 5'd1, 5'd2);
    cycle("ill_63");
    set_id(6'd1, 6'd0, 5'd1, 5'd3);
    cycle("ill_regimm");
    set_id(6'd1, 6'd0, 5'd1, 5'd0);
    cycle("bltz");

    // Reset in the middle of a stall.
    set_ex(1'b1, 5'd5);
    set_id(6'd0, 6'd34, 5'd1, 5'd5);
    cycle("rs_hz");
    Reset = 1'b1;
    cycle("rs_mid");
    Reset = 1'b0;
    set_ex(1'b0, 5'd0);
    cycle("rs_issue");

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      Reset       = ($urandom_range(0, 59) == 0);
      BranchTaken = ($urandom_range(0, 11) == 0);
      set_id(op_pool[$urandom_range(0, 21)],
             ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_pool[$urandom_range(0, 5)],
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      ID_Valid = ($urandom_range(0, 7) != 0);
      set_ex($urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)));
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
